// File: rtl/perf_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : perf_event_monitor
// Description : Performance monitor placed beside the pipelined processor.
//               Counts cycles, retired instructions and NUM_CH generic event
//               strobes (cache requests/hits etc.). All counting stops once a
//               halt is seen and resumes only after clr. A registered read
//               port returns any counter two edges after the request is
//               sampled.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1         system clock, rising edge
//   rst      in   1         asynchronous reset, active-high
//   clr      in   1         synchronous clear of counters/flags, back to RUN
//   en       in   1         global count enable
//   retire   in   1         instruction retired this cycle
//   halt     in   1         halt reached memory/writeback this cycle
//   evt      in   NUM_CH    per-channel event strobes
//   rd_req   in   1         read request pulse
//   rd_sel   in   SEL_W     0=cycles, 1=instructions, 2+k=event channel k
//   rd_valid out  1         rd_data valid pulse
//   rd_data  out  CNT_W     selected counter value (holds when not valid)
//   rd_err   out  1         with rd_valid: rd_sel out of range
//   frozen   out  1         high while counting is frozen by a halt
//   ovf      out  NUM_CH+2  sticky overflow flags, rd_sel index order
// ============================================================================
module perf_event_monitor #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = 0,
  parameter int SEL_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              retire,
  input  logic              halt,
  input  logic [NUM_CH-1:0] evt,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_err,
  output logic              frozen,
  output logic [NUM_CH+1:0] ovf
);

  localparam int               NCNT    = NUM_CH + 2;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q [NCNT];
  logic [CNT_W-1:0]  cnt_d [NCNT];
  logic [NCNT-1:0]   ovf_q;
  logic [NCNT-1:0]   ovf_d;
  logic [NCNT-1:0]   inc;
  logic              count_en;

  // Read pipeline: stage 1 samples the counter register, stage 2 presents it.
  logic              pend_q;
  logic              pend_err_q;
  logic [CNT_W-1:0]  pend_data_q;
  logic              rd_valid_q;
  logic              rd_err_q;
  logic [CNT_W-1:0]  rd_data_q;
  logic [CNT_W-1:0]  rd_pick;
  logic              sel_ok;

  // clr takes priority over counting in the same cycle.
  assign count_en = (state_q == ST_RUN) && en && !clr;

  // Increment requests in rd_sel order: cycle counter always, then
  // instructions (a halt counts as one), then the event channels.
  assign inc = {evt, (retire | halt), 1'b1};

  always_comb begin
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (count_en && inc[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
          // Saturating mode simply keeps the all-ones value.
          if (SAT_MODE == 0) begin
            cnt_d[i] = '0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Compare-based mux so out-of-range selects never index past the array.
  always_comb begin
    rd_pick = '0;
    sel_ok  = 1'b0;
    for (int i = 0; i < NCNT; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_pick = cnt_q[i];
        sel_ok  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q       <= '0;
      pend_q      <= 1'b0;
      pend_err_q  <= 1'b0;
      pend_data_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      // The read path ignores clr so an in-flight read returns pre-clear data.
      pend_q      <= rd_req;
      pend_err_q  <= rd_req && !sel_ok;
      pend_data_q <= rd_pick;
      rd_valid_q  <= pend_q;
      rd_err_q    <= pend_q && pend_err_q;
      if (pend_q) begin
        rd_data_q <= pend_data_q;
      end

      if (clr) begin
        state_q <= ST_RUN;
        for (int i = 0; i < NCNT; i++) begin
          cnt_q[i] <= '0;
        end
        ovf_q <= '0;
      end else begin
        for (int i = 0; i < NCNT; i++) begin
          cnt_q[i] <= cnt_d[i];
        end
        ovf_q <= ovf_d;
        // The halt cycle itself has already been counted above.
        if (count_en && halt) begin
          state_q <= ST_FROZEN;
        end
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_data  = rd_data_q;
  assign frozen   = (state_q == ST_FROZEN);
  assign ovf      = ovf_q;

endmodule
`default_nettype wire
